// File: rtl/srjk_ff_bank.sv
// srjk_ff_bank: bank of WIDTH flip-flops with a run-time selectable function
// (SR, JK, D or T), per-bit synchronous clear/preset, a clock enable and
// registered per-bit change pulses.
// Optional feature macro: SRJK_FF_ILLEGAL_FLAG_EN adds sticky per-bit flags
// for the SR "both inputs high" condition; without it ERR is tied low.
module srjk_ff_bank #(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic [1:0]       MODE,
  input  logic             CE,
  input  logic [WIDTH-1:0] SC,
  input  logic [WIDTH-1:0] PR,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic [WIDTH-1:0] CHG,
  output logic [WIDTH-1:0] ERR
);

  localparam logic [1:0] MODE_SR = 2'd0;
  localparam logic [1:0] MODE_JK = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_T  = 2'd3;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic [WIDTH-1:0] r_chg_pend;
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] w_q_nxt;

  // Per-bit next state: SC beats PR, both beat CE, then the MODE function.
  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (SC[i]) begin
        w_q_nxt[i] = 1'b0;
      end else if (PR[i]) begin
        w_q_nxt[i] = 1'b1;
      end else if (CE) begin
        case (MODE)
          MODE_SR: begin
            case ({S[i], R[i]})
              2'b10:   w_q_nxt[i] = 1'b1;
              2'b01:   w_q_nxt[i] = 1'b0;
              default: w_q_nxt[i] = r_q[i];
            endcase
          end
          MODE_JK: begin
            case ({S[i], R[i]})
              2'b10:   w_q_nxt[i] = 1'b1;
              2'b01:   w_q_nxt[i] = 1'b0;
              2'b11:   w_q_nxt[i] = ~r_q[i];
              default: w_q_nxt[i] = r_q[i];
            endcase
          end
          MODE_D:  w_q_nxt[i] = S[i];
          MODE_T:  w_q_nxt[i] = S[i] ^ r_q[i];
          default: w_q_nxt[i] = r_q[i];
        endcase
      end
    end
  end

  // State, its complement, and a two-step change pulse (detect, then present).
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      r_q        <= RESET_VAL;
      r_qbar     <= ~RESET_VAL;
      r_chg_pend <= '0;
      r_chg      <= '0;
    end else begin
      r_q        <= w_q_nxt;
      r_qbar     <= ~w_q_nxt;
      r_chg_pend <= w_q_nxt ^ r_q;
      r_chg      <= r_chg_pend;
    end
  end

  assign Q    = r_q;
  assign QBAR = r_qbar;
  assign CHG  = r_chg;

`ifdef SRJK_FF_ILLEGAL_FLAG_EN
  logic [WIDTH-1:0] r_err;
  logic [WIDTH-1:0] w_viol;

  // An SR "11" only counts when the function actually gets to evaluate it.
  always_comb begin
    w_viol = '0;
    if ((MODE == MODE_SR) && CE) begin
      w_viol = S & R & ~SC & ~PR;
    end
  end

  // Sticky flags; a new violation wins over a simultaneous clear request.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      r_err <= '0;
    end else begin
      r_err <= w_viol | (ERR_CLR ? '0 : r_err);
    end
  end

  assign ERR = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = ERR_CLR;
  assign ERR = '0;
`endif

endmodule

// File: tb/tb_srjk_ff_bank.sv
// Self-checking bench for srjk_ff_bank (WIDTH=4, RESET_VAL=4'b0101).
// A mask-based reference model tracks the expected outputs; a compare
// process checks every falling edge, and directed steps pin literal values.
module tb_srjk_ff_bank;

  localparam int           W  = 4;
  localparam logic [W-1:0] RV = 4'b0101;
`ifdef SRJK_FF_ILLEGAL_FLAG_EN
  localparam logic [W-1:0] E_ERR = 4'b0100;
`else
  localparam logic [W-1:0] E_ERR = 4'b0000;
`endif

  logic         CK = 1'b0;
  logic         CLR = 1'b0;
  logic [1:0]   MODE = 2'd0;
  logic         CE = 1'b0;
  logic [W-1:0] SC = '0;
  logic [W-1:0] PR = '0;
  logic [W-1:0] S = '0;
  logic [W-1:0] R = '0;
  logic         ERR_CLR = 1'b0;
  logic [W-1:0] Q, QBAR, CHG, ERR;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [W-1:0] m_q = RV, m_pend = '0, m_chg = '0, m_err = '0;
  logic [W-1:0] set_m, clr_m, tog_m, q_fn, q_new, viol;

  srjk_ff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .CK(CK), .CLR(CLR), .MODE(MODE), .CE(CE), .SC(SC), .PR(PR),
    .S(S), .R(R), .ERR_CLR(ERR_CLR),
    .Q(Q), .QBAR(QBAR), .CHG(CHG), .ERR(ERR)
  );

  always #5 CK = ~CK;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the function expressed as set/clear/toggle masks, then SC/PR override.
  always @(posedge CK or posedge CLR) begin
    if (CLR) begin
      m_q = RV; m_pend = '0; m_chg = '0; m_err = '0;
    end else begin
      set_m = '0; clr_m = '0; tog_m = '0; viol = '0;
      if (CE) begin
        case (MODE)
          2'd0: begin set_m = S & ~R; clr_m = R & ~S; viol = S & R & ~SC & ~PR; end
          2'd1: begin set_m = S & ~R; clr_m = R & ~S; tog_m = S & R; end
          2'd2: begin set_m = S; clr_m = ~S; end
          default: tog_m = S;
        endcase
      end
      q_fn  = ((m_q ^ tog_m) | set_m) & ~clr_m;
      q_new = (q_fn | PR) & ~SC;
      m_chg = m_pend;
      m_pend = q_new ^ m_q;
      m_q = q_new;
`ifdef SRJK_FF_ILLEGAL_FLAG_EN
      m_err = viol | (ERR_CLR ? '0 : m_err);
`else
      m_err = '0;
`endif
    end
  end

  // Compare process: every falling edge once reset has been applied.
  always @(negedge CK) begin
    if (chk_en) begin
      chk("Q", Q, m_q);
      chk("QBAR", QBAR, ~m_q);
      chk("CHG", CHG, m_chg);
      chk("ERR", ERR, m_err);
    end
  end

  task automatic cyc();
    @(posedge CK);
    @(negedge CK);
    #1;
  endtask

  task automatic drv(input logic [1:0] md, input logic ce, input logic [W-1:0] s,
                     input logic [W-1:0] r, input logic [W-1:0] sc, input logic [W-1:0] pr);
    MODE = md; CE = ce; S = s; R = r; SC = sc; PR = pr;
  endtask

  initial begin
    // Asynchronous reset with no clock edge
    #2 CLR = 1'b1;
    #1;
    chk("rst_q", Q, 4'b0101);
    chk("rst_qbar", QBAR, 4'b1010);
    chk("rst_chg", CHG, 4'b0000);
    chk("rst_err", ERR, 4'b0000);
    chk("model_rst_q", m_q, 4'b0101);
    chk_en = 1'b1;
    @(negedge CK); #1;
    CLR = 1'b0;
    drv(2'd0, 1'b0, 4'b1111, 4'b0000, '0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ce0_hold_q", Q, 4'b0101);
    end

    // SR set/reset and change pulse latency
    drv(2'd0, 1'b1, 4'b0011, 4'b1100, '0, '0);
    cyc();
    chk("sr_q", Q, 4'b0011);
    chk("sr_qbar", QBAR, 4'b1100);
    chk("sr_chg_early", CHG, 4'b0000);
    drv(2'd0, 1'b1, 4'b0000, 4'b0000, '0, '0);
    cyc();
    chk("sr_chg", CHG, 4'b0110);
    chk("model_sr_chg", m_chg, 4'b0110);
    cyc();
    chk("sr_chg_clear", CHG, 4'b0000);

    // JK toggle twice, then T
    drv(2'd1, 1'b1, 4'b1111, 4'b1111, '0, '0);
    cyc();
    chk("jk_tog1", Q, 4'b1100);
    cyc();
    chk("jk_tog2", Q, 4'b0011);
    drv(2'd3, 1'b1, 4'b0001, 4'b0000, '0, '0);
    cyc();
    chk("t_q", Q, 4'b0010);

    // D with SC/PR override, then the same with CE=0
    drv(2'd2, 1'b1, 4'b1010, 4'b0000, 4'b1000, 4'b0101);
    cyc();
    chk("d_scpr_q", Q, 4'b0111);
    chk("model_d_scpr_q", m_q, 4'b0111);
    drv(2'd2, 1'b1, 4'b0010, 4'b0000, '0, '0);
    cyc();
    chk("d_q", Q, 4'b0010);
    drv(2'd2, 1'b0, 4'b1010, 4'b0000, 4'b1000, 4'b0101);
    cyc();
    chk("ce0_scpr_q", Q, 4'b0111);

    // Illegal SR input and sticky flag
    drv(2'd0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    cyc();
    chk("sc_all_q", Q, 4'b0000);
    drv(2'd0, 1'b1, 4'b0100, 4'b0100, '0, '0);
    cyc();
    chk("sr11_q", Q, 4'b0000);
    chk("sr11_err", ERR, E_ERR);
    drv(2'd0, 1'b1, 4'b0000, 4'b0000, '0, '0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("err_sticky", ERR, E_ERR);
    end
    ERR_CLR = 1'b1;
    cyc();
    ERR_CLR = 1'b0;
    chk("err_clr", ERR, 4'b0000);

    // MODE change takes effect on the same edge
    drv(2'd1, 1'b1, 4'b1111, 4'b1111, '0, '0);
    cyc();
    chk("mode_sw_q", Q, 4'b1111);
    chk("mode_sw_err", ERR, 4'b0000);

    // Reset coincident with a rising edge
    @(posedge CK);
    CLR = 1'b1;
    @(negedge CK); #1;
    chk("clr_edge_q", Q, 4'b0101);
    chk("clr_edge_chg", CHG, 4'b0000);
    chk("clr_edge_qbar", QBAR, 4'b1010);
    CLR = 1'b0;
    drv(2'd0, 1'b0, '0, '0, '0, '0);
    cyc();
    chk("post_clr_chg", CHG, 4'b0000);

    // Randomised phase checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      int sel;
      CLR = 1'b0;
      MODE = 2'($urandom_range(0, 3));
      CE = ($urandom_range(0, 3) != 0);
      S = W'($urandom);
      R = W'($urandom);
      SC = W'($urandom & $urandom & $urandom);
      PR = W'($urandom & $urandom & $urandom);
      ERR_CLR = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 63);
      if (sel == 0) begin
        CLR = 1'b1;
      end else if (sel == 1) begin
        #1 CLR = 1'b1;
        #1 CLR = 1'b0;
      end
      cyc();
    end
    CLR = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
